m1_gates: RTL and testbench

M1_GATES -- requirements
Module: m1_gates

---
 rtl/m1_gates_pkg.sv | 22 ++
 rtl/m1_gates_lane.sv | 38 +++
 rtl/m1_gates.sv | 44 ++++
 tb/tb_m1_gates.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m1_gates_pkg.sv
// Shared constants and the saturating run-counter step for m1_gates.
package m1_gates_pkg;

    localparam int CNT_W             = 8;
    localparam int STABLE_CYCLES_DEF = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Count up while the lane is high, hold at lim, clear on any low sample.
    function automatic cnt_t cnt_step(input cnt_t q, input logic hit, input cnt_t lim);
        cnt_t r;
        if (!hit) begin
            r = '0;
        end else if (q >= lim) begin
            r = lim;
        end else begin
            r = q + cnt_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/m1_gates_lane.sv
// One debounce lane: run counter plus its registered qualified output bit.
module m1_gates_lane
    import m1_gates_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic hit_i,
    output logic e_o
);

    localparam cnt_t LIMIT = cnt_t'(STABLE_CYCLES);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic e_q;
    logic e_d;

    always_comb begin
        cnt_d = cnt_step(cnt_q, hit_i, LIMIT);
        e_d   = (cnt_d == LIMIT);
    end

    // e_q mirrors (cnt_q == LIMIT) but comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            e_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            e_q   <= e_d;
        end
    end

    assign e_o = e_q;

endmodule

// File: rtl/m1_gates.sv
// AND gate with combinational, registered and per-bit debounced outputs.
module m1_gates
    import m1_gates_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
);

    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] d_q;

    assign and_d = a & b;
    assign c     = and_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= and_d;
        end
    end

    assign d = d_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        m1_gates_lane #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .hit_i(and_d[i]),
            .e_o  (e[i])
        );
    end

endmodule

// File: tb/tb_m1_gates.sv
// Bench for m1_gates: directed scenarios plus random traffic against a run-length model.
module tb_m1_gates;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] c, d, e;
    logic [3:0] c1, d1, e1;
    logic       a_s = 1'b0;
    logic       b_s = 1'b0;
    logic       c_s, d_s, e_s;

    int errors = 0;
    int checks = 0;

    // Model: length of the current run of sampled-high cycles per lane.
    int         run [4];
    int         run_s;
    logic [3:0] m_d;

    always #5 clk = ~clk;

    m1_gates #(.WIDTH(4), .STABLE_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e)
    );

    m1_gates #(.WIDTH(4), .STABLE_CYCLES(1)) u_one (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c1), .d(d1), .e(e1)
    );

    m1_gates #(.WIDTH(1), .STABLE_CYCLES(255)) u_sat (
        .clk(clk), .rst(rst), .a(a_s), .b(b_s), .c(c_s), .d(d_s), .e(e_s)
    );

    function automatic logic [3:0] exp_e(input int lim);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (run[i] >= lim);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) run[i] = 0;
            run_s = 0;
            m_d   = '0;
        end else begin
            for (int i = 0; i < 4; i++) run[i] = (a[i] & b[i]) ? run[i] + 1 : 0;
            run_s = (a_s & b_s) ? run_s + 1 : 0;
            m_d   = a & b;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        a_s = 1'b1;
        b_s = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (c !== 4'hF) begin
            errors++;
            $display("FAIL reset_c: got %h want %h", c, 4'hF);
        end
        checks++;
        if (d !== 4'h0 || e !== 4'h0) begin
            errors++;
            $display("FAIL reset_de: got d=%h e=%h want 0 0", d, e);
        end
        checks++;
        if (d1 !== 4'h0 || e1 !== 4'h0 || d_s !== 1'b0 || e_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_other: got d1=%h e1=%h d_s=%b e_s=%b want 0", d1, e1, d_s, e_s);
        end
        a_s = 1'b0;
        b_s = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] pat;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            pat = 2'(p);
            a   = {3'b000, pat[1]};
            b   = {3'b000, pat[0]};
            #1;
            checks++;
            if (c[0] !== (p == 3)) begin
                errors++;
                $display("FAIL tt_c p=%0d: got %b want %b", p, c[0], (p == 3));
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (d !== m_d || e !== exp_e(2)) begin
                    errors++;
                    $display("FAIL tt_de p=%0d k=%0d: got d=%h e=%h want d=%h e=%h",
                             p, k, d, e, m_d, exp_e(2));
                end
            end
        end
    endtask

    task automatic test_debounce();
        logic [3:0] want [3];
        want[0] = 4'h0;
        want[1] = 4'hF;
        want[2] = 4'hF;
        do_reset();
        a = 4'hF;
        b = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (e !== want[k]) begin
                errors++;
                $display("FAIL debounce_edge%0d: got %h want %h", k + 1, e, want[k]);
            end
        end
        b = 4'h0;
        tick();
        checks++;
        if (e !== 4'h0) begin
            errors++;
            $display("FAIL debounce_drop: got %h want 0", e);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        a = 4'hF;
        b = 4'hF;
        tick();
        checks++;
        if (d !== 4'hF || e !== 4'h0) begin
            errors++;
            $display("FAIL glitch_pulse: got d=%h e=%h want d=f e=0", d, e);
        end
        b = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (d !== 4'h0 || e !== 4'h0) begin
                errors++;
                $display("FAIL glitch_after%0d: got d=%h e=%h want 0 0", k, d, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        a = 4'hF;
        b = 4'hF;
        tick();
        tick();
        tick();
        checks++;
        if (e !== 4'hF) begin
            errors++;
            $display("FAIL midrun_pre: got %h want f", e);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (d !== 4'h0 || e !== 4'h0) begin
            errors++;
            $display("FAIL midrun_rst: got d=%h e=%h want 0 0", d, e);
        end
        tick();
        checks++;
        if (e !== 4'h0 || d !== 4'hF) begin
            errors++;
            $display("FAIL midrun_edge1: got d=%h e=%h want d=f e=0", d, e);
        end
        tick();
        checks++;
        if (e !== 4'hF) begin
            errors++;
            $display("FAIL midrun_edge2: got %h want f", e);
        end
    endtask

    task automatic test_lanes();
        do_reset();
        a = 4'hF;
        b = 4'h5;
        #1;
        checks++;
        if (c !== 4'h5) begin
            errors++;
            $display("FAIL lanes_c: got %h want 5", c);
        end
        tick();
        tick();
        checks++;
        if (e !== 4'h5 || e1 !== 4'h5) begin
            errors++;
            $display("FAIL lanes_e: got e=%h e1=%h want 5 5", e, e1);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            a   = 4'($urandom) | 4'($urandom) | 4'($urandom);
            b   = 4'($urandom) | 4'($urandom) | 4'($urandom);
            #1;
            checks++;
            if (c !== (a & b)) begin
                errors++;
                $display("FAIL rand_c k=%0d: got %h want %h", k, c, a & b);
            end
            tick();
            checks++;
            if (d !== m_d || e !== exp_e(2)) begin
                errors++;
                $display("FAIL rand_de k=%0d: got d=%h e=%h want d=%h e=%h",
                         k, d, e, m_d, exp_e(2));
            end
            checks++;
            if (e1 !== exp_e(1) || e1 !== d1) begin
                errors++;
                $display("FAIL rand_sc1 k=%0d: got e1=%h d1=%h want %h", k, e1, d1, exp_e(1));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        a_s = 1'b1;
        b_s = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            checks++;
            if (e_s !== (run_s >= 255) || e_s !== (k >= 255)) begin
                errors++;
                $display("FAIL sat_edge%0d: got %b want %b", k, e_s, (k >= 255));
            end
        end
        a_s = 1'b0;
        tick();
        checks++;
        if (e_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_drop: got %b want 0", e_s);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) run[i] = 0;
        run_s = 0;
        m_d   = '0;
        test_reset();
        test_truth_table();
        test_debounce();
        test_glitch();
        test_reset_mid_run();
        test_lanes();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
